// File: rtl/fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, the reset NOP, and the RV32I
// major opcodes that the controller decodes from opc.
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'b00,
    EXEC  = 2'b01,
    HALT  = 2'b10
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] BT   = 7'b1100011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC mux: jalr target beats branch/jal target, which beats pc+4.
// All adds wrap modulo 2^XLEN.
module next_pc_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  input  logic            PC_src,
  input  logic            is_jalr,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misaligned
);

  assign pc_plus4 = pc + XLEN'(4);

  always_comb begin
    next_pc = pc_plus4;
    if (is_jalr)
      next_pc = alu_result & ~XLEN'(1);
    else if (PC_src)
      next_pc = pc + imm_ext;
  end

  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I multi-cycle fetch front end: PC register, imem handshake, instruction latch.
// Optional FETCH_PERF_CNT_EN adds retired/redirect counters.
//
// state | meaning
// FETCH | imem_req high, waiting for imem_ready to latch instr
// EXEC  | instr valid for controller; advance pc unless exec_stall
// HALT  | redirect target misaligned; frozen until rst
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  input  logic            exec_stall,
  input  logic            PC_src,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] imm_ext,
  input  logic [XLEN-1:0] alu_result,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic [6:0]      opc,
  output logic [2:0]      f3,
  output logic [6:0]      f7,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     retired_cnt,
  output logic [31:0]     redirect_cnt,
`endif
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            misalign_q;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            exec_advance;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .pc         (pc_q),
    .imm_ext    (imm_ext),
    .alu_result (alu_result),
    .PC_src     (PC_src),
    .is_jalr    (is_jalr),
    .next_pc    (next_pc),
    .pc_plus4   (pc_plus4),
    .misaligned (misaligned)
  );

  assign exec_advance = (state_q == EXEC) && !exec_stall;

  always_comb begin
    state_d     = state_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_d = EXEC;
      end
      EXEC: begin
        instr_valid = 1'b1;
        if (!exec_stall) state_d = misaligned ? HALT : FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      misalign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == FETCH && imem_ready) instr_q <= imem_rdata;
      // A misaligned target freezes pc at the offending instruction
      if (exec_advance) begin
        if (misaligned) misalign_q <= 1'b1;
        else            pc_q       <= next_pc;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt  <= '0;
      redirect_cnt <= '0;
    end else if (exec_advance && !misaligned) begin
      retired_cnt <= retired_cnt + 32'd1;
      if (next_pc != pc_plus4) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign instr        = instr_q;
  assign misalign_err = misalign_q;
  assign opc          = instr_q[6:0];
  assign rd           = instr_q[11:7];
  assign f3           = instr_q[14:12];
  assign rs1          = instr_q[19:15];
  assign rs2          = instr_q[24:20];
  assign f7           = instr_q[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit; build with +define+FETCH_PERF_CNT_EN
// to also exercise the counters.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        exec_stall;
  logic        PC_src;
  logic        is_jalr;
  logic [31:0] imm_ext;
  logic [31:0] alu_result;
  logic [31:0] instr;
  logic        instr_valid;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] retired_cnt;
  logic [31:0] redirect_cnt;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] W0  = {7'b0100000, 5'd7, 5'd21, 3'b101, 5'd9, 7'b0110011};
  localparam logic [31:0] W1  = 32'hDEAD_BEEF;
  localparam logic [31:0] W2  = 32'h1234_5678;
  localparam logic [31:0] W3  = 32'h00A0_0093;
  localparam logic [31:0] NOP = 32'h0000_0013;

  instr_fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .exec_stall   (exec_stall),
    .PC_src       (PC_src),
    .is_jalr      (is_jalr),
    .imm_ext      (imm_ext),
    .alu_result   (alu_result),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .opc          (opc),
    .f3           (f3),
    .f7           (f7),
    .rs1          (rs1),
    .rs2          (rs2),
    .rd           (rd),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
`ifdef FETCH_PERF_CNT_EN
    .retired_cnt  (retired_cnt),
    .redirect_cnt (redirect_cnt),
`endif
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", tag, act, exp);
    end
  endtask

  // One rising edge, then sample on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ctl(input logic src, input logic jalr, input logic [31:0] imm, input logic [31:0] alu);
    PC_src = src; is_jalr = jalr; imm_ext = imm; alu_result = alu;
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b1; imem_rdata = W0; exec_stall = 1'b0;
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    repeat (2) tick();
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_instr", instr, NOP);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_merr", {31'b0, misalign_err}, 32'd0);
    rst = 1'b0;

    // single-cycle fetch of word 0
    tick();
    chk("f0_valid", {31'b0, instr_valid}, 32'd1);
    chk("f0_instr", instr, W0);
    chk("f0_req", {31'b0, imem_req}, 32'd0);
    chk("f0_opc", {25'b0, opc}, 32'h33);
    chk("f0_rd", {27'b0, rd}, 32'd9);
    chk("f0_f3", {29'b0, f3}, 32'd5);
    chk("f0_rs1", {27'b0, rs1}, 32'd21);
    chk("f0_rs2", {27'b0, rs2}, 32'd7);
    chk("f0_f7", {25'b0, f7}, 32'h20);
    chk("f0_pc4", pc_plus4, 32'h4);
    tick();
    chk("seq_addr", imem_addr, 32'h4);
    chk("seq_req", {31'b0, imem_req}, 32'd1);

    // imem_ready low for 3 cycles
    imem_ready = 1'b0; imem_rdata = W1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_req", {31'b0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h4);
      chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    tick();
    chk("wait_instr", instr, W1);
    chk("wait_valid4", {31'b0, instr_valid}, 32'd1);

    // branch to 0x10, then backward branch by -8
    ctl(1'b1, 1'b0, 32'h0000_000C, 32'h0);
    tick();
    chk("br_addr10", imem_addr, 32'h10);
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    ctl(1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0);
    tick();
    chk("br_back", imem_addr, 32'h08);
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    // jalr beats PC_src and clears bit 0
    ctl(1'b1, 1'b1, 32'hFFFF_FFF8, 32'h0000_0101);
    tick();
    chk("jalr_prio", imem_addr, 32'h100);
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    imem_rdata = W2;
    tick();
    chk("jalr_instr", instr, W2);

    // stall holds EXEC
    exec_stall = 1'b1; imem_rdata = W3;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_pc", pc, 32'h100);
      chk("stall_instr", instr, W2);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
    end
    exec_stall = 1'b0;
    tick();
    chk("stall_adv", imem_addr, 32'h104);

    // wrap: 0x104 + 0xFFFF_FEF8 = 0xFFFF_FFFC, then +4 wraps to 0
    tick();
    ctl(1'b1, 1'b0, 32'hFFFF_FEF8, 32'h0);
    tick();
    chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("wrap_pc4", pc_plus4, 32'h0);
    tick();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_merr", {31'b0, misalign_err}, 32'd0);

    // misaligned jalr target halts
    tick();
    ctl(1'b0, 1'b1, 32'h0, 32'h0000_0006);
    tick();
    chk("halt_merr", {31'b0, misalign_err}, 32'd1);
    chk("halt_pc", pc, 32'h0);
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_req", {31'b0, imem_req}, 32'd0);
      chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("unhalt_merr", {31'b0, misalign_err}, 32'd0);
    chk("unhalt_req", {31'b0, imem_req}, 32'd1);
    chk("unhalt_addr", imem_addr, 32'h0);

    // reset during FETCH with ready high: no latch
    imem_rdata = W1;
    tick();
    tick();
    chk("pre_rst_addr", imem_addr, 32'h4);
    rst = 1'b1; imem_rdata = W3;
    tick();
    rst = 1'b0;
    chk("rstf_instr", instr, NOP);
    chk("rstf_pc", pc, 32'h0);
    chk("rstf_valid", {31'b0, instr_valid}, 32'd0);

`ifdef FETCH_PERF_CNT_EN
    chk("cnt_rst_ret", retired_cnt, 32'd0);
    chk("cnt_rst_red", redirect_cnt, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      tick();
    end
    tick();
    ctl(1'b1, 1'b0, 32'h0000_0020, 32'h0);
    tick();
    ctl(1'b0, 1'b0, 32'h0, 32'h0);
    chk("cnt_addr", imem_addr, 32'h2C);
    chk("cnt_ret", retired_cnt, 32'd4);
    chk("cnt_red", redirect_cnt, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the multi-cycle RV32I core, directly upstream of the main controller.
- Holds the PC and fetches from instruction memory using a ready handshake.
- Latches the instruction and drives the decoded fields (opc, f3, f7, rs1, rs2, rd) to the controller and register file.
- Consumes the controller's PC_src and is_jalr, plus the ALU result and the extended immediate, to choose the next PC.

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; everything updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request, high throughout FETCH
- imem_addr  out  XLEN  fetch address (= pc)
- imem_ready  in  1  memory has valid imem_rdata this cycle
- imem_rdata  in  32  instruction word from memory
- exec_stall  in  1  hold current instruction in EXEC (data-memory wait)
- PC_src  in  1  from controller: take pc+imm_ext
- is_jalr  in  1  from controller: take alu_result & ~1
- imm_ext  in  XLEN  sign-extended immediate
- alu_result  in  XLEN  ALU output (jalr target)
- instr  out  32  latched instruction
- instr_valid  out  1  instr/fields valid; high in EXEC only
- opc  out  7  instr[6:0]
- f3  out  3  instr[14:12]
- f7  out  7  instr[31:25]
- rs1  out  5  instr[19:15]
- rs2  out  5  instr[24:20]
- rd  out  5  instr[11:7]
- pc  out  XLEN  PC of the current instruction
- pc_plus4  out  XLEN  pc+4, used for the jal/jalr link value
- misalign_err  out  1  sticky: redirect target not word aligned

Behaviour:
- Reset (rst sampled high at an edge):
  - state=FETCH, pc=RESET_PC, instr=32'h0000_0013 (NOP), misalign_err=0.
  - Reset wins over every other event, including mid-FETCH (the outstanding request is dropped, with no instr latch) and mid-EXEC (no PC update).
- FETCH:
  - imem_req=1, imem_addr=pc, instr_valid=0.
  - If imem_ready=1: instr<=imem_rdata, next state EXEC.
  - If imem_ready is high on the first FETCH cycle, the fetch takes 1 cycle; there is no timeout.
- EXEC:
  - imem_req=0, instr_valid=1.
  - Controller inputs are combinational from instr and are sampled at the end of the cycle.
  - If exec_stall=1: stay in EXEC; pc and instr hold.
  - Otherwise pc<=next_pc and next state FETCH, unless the target is misaligned (see HALT).
- HALT:
  - Entered from EXEC when next_pc[1:0]!=0.
  - misalign_err<=1 and pc does not change.
  - imem_req=0, instr_valid=0; left only by rst.
- next_pc priority:
  1. is_jalr: {alu_result[XLEN-1:1],1'b0}
  2. else PC_src: pc+imm_ext
  3. else pc+4
- If is_jalr and PC_src are both high, is_jalr wins.
- All adds are modulo 2^XLEN: pc=32'hFFFF_FFFC plus 4 wraps to 0 with no flag.
- Minimum throughput is 2 cycles per instruction.
- Decoded fields are pure slices of the instr register, so they are valid from the cycle after the latch.

Optional Feature:
- FETCH_PERF_CNT_EN defined:
  - Adds outputs retired_cnt[31:0] and redirect_cnt[31:0], both reset to 0.
  - retired_cnt increments on each EXEC→FETCH transition.
  - redirect_cnt increments on each EXEC→FETCH transition whose next_pc != pc+4.
  - Both counters wrap silently.
- Undefined: the ports and logic are absent.

Decomposition:
- Package fetch_pkg:
  - State encoding: FETCH=2'b00, EXEC=2'b01, HALT=2'b10.
  - NOP_INSTR constant.
  - Opcode constants shared with the controller (LW, SW, RT, BT, IT, LUI, JAL, JALR).
- One combinational sub-module, next_pc_sel:
  - Inputs: pc, imm_ext, alu_result, PC_src, is_jalr.
  - Outputs: next_pc, pc_plus4, misaligned.
- The FSM and registers stay in instr_fetch_unit.

Test Plan:
- rst high 2 cycles then low, imem_ready tied 1 → cycle 1: imem_req=1, imem_addr=0; cycle 2: instr_valid=1, instr matches memory[0]; cycle 3: imem_addr=4.
- imem_ready held low 3 cycles in FETCH → imem_req stays 1, imem_addr stable, instr_valid=0; instr latched on the 4th cycle.
- pc=0x10, EXEC with PC_src=1, imm_ext=0xFFFF_FFF8 → next fetch address 0x08. With is_jalr=1 and alu_result=0x0000_0101 as well → next fetch address 0x100 (is_jalr priority, bit0 cleared).
- exec_stall=1 for 2 EXEC cycles → pc and instr unchanged, instr_valid=1 throughout; advances on the cycle stall drops.
- jalr to alu_result=0x0000_0006 → misalign_err=1, imem_req=0 forever; rst pulse → misalign_err=0, fetch from RESET_PC.
- rst asserted during FETCH while imem_ready=1 → instr stays NOP, pc=RESET_PC. With FETCH_PERF_CNT_EN, after 3 sequential instructions plus 1 taken branch: retired_cnt=4, redirect_cnt=1.
